mesh_node_adapter: RTL and testbench
====================================

// Module: mesh_node_adapter
// PURPOSE
//  Per-node network interface on a mesh local port; packet-level traffic on one side, flit-level on the other.
//  Injection: queues packet requests, splits each into HEAD/BODY/TAIL flits (HEADTAIL if 1 flit),
//  selects a free VC round-robin and honours per-VC on/off flow control.
//  Ejection: sinks flits per VC, reassembles packets, flags protocol errors, drives on/off + allocatable back.
// PARAMETERS
//  REQ_DEPTH      4   packet request queue depth (power of 2, >=2)
//  MAX_PKT_FLITS  8   max flits per packet (>=1)
//  X_CURRENT      0   this node's column; source field of injected heads
//  Y_CURRENT      0   this node's row
// PORTS
//  clk               in   1                   clock
//  rst               in   1                   synchronous reset, active-high
//  req_valid_i       in   1                   packet request valid
//  req_ready_o       out  1                   queue not full
//  req_dest_x_i      in   DEST_ADDR_SIZE_X    destination column
//  req_dest_y_i      in   DEST_ADDR_SIZE_Y    destination row
//  req_len_i         in   $clog2(MAX_PKT_FLITS+1)  flits in packet, 1..MAX_PKT_FLITS
//  flit_o            out  flit_t              flit to mesh local input
//  flit_valid_o      out  1                   flit_o valid this cycle
//  on_off_i          in   VC_NUM              per-VC space at router local input
//  allocatable_i     in   VC_NUM              per-VC free-for-new-packet at router local input
//  flit_i            in   flit_t              flit from mesh local output
//  flit_valid_i      in   1                   flit_i valid
//  on_off_o          out  VC_NUM              per-VC space here
//  allocatable_o     out  VC_NUM              per-VC idle here
//  rx_pkt_valid_o    out  1                   1-cycle pulse: packet completed
//  rx_pkt_len_o      out  $clog2(MAX_PKT_FLITS+1)  flits in completed packet
//  rx_err_o          out  VC_NUM              sticky per-VC protocol error
// BEHAVIOUR
//  Reset: all outputs 0; queue empty; FSM IDLE; RR pointer VC 0; all RX VCs idle.
//  Queue: push when req_valid_i&&req_ready_o; req_len_i==0 or >MAX_PKT_FLITS not pushed, sets no error (dropped).
//  TX FSM: IDLE->SEL when queue non-empty; SEL picks first VC v from RR ptr with allocatable_i[v];
//   none -> stay SEL. SEL->SEND next cycle; RR ptr := v+1 mod VC_NUM.
//  SEND: flit_valid_o=1 only in cycles with on_off_i[v]=1; vc_id=v; flit k (0-based) data = {seq,k}.
//   label HEAD k=0, TAIL k=len-1, HEADTAIL if len==1, else BODY.
//   after last flit: pop queue, seq++ (wraps 8 bits), ->IDLE. Min 3 cycles/packet, no back-to-back overlap.
//  on_off_i drop mid-packet: stall at same k, no flit lost or duplicated.
//  Head carries dest x/y, src X_CURRENT/Y_CURRENT.
//  RX per VC: IDLE --HEAD--> OPEN; OPEN --BODY--> OPEN (count++);
//   OPEN --TAIL--> IDLE with rx_pkt_valid_o next cycle. HEADTAIL in IDLE -> pulse, len 1.
//   BODY/TAIL while IDLE, HEAD/HEADTAIL while OPEN, count>MAX_PKT_FLITS -> rx_err_o[v] sticky until rst;
//   VC forced IDLE, flit discarded.
//  on_off_o = all 1 from first cycle after rst (always sinks). allocatable_o[v] = 1 iff RX VC v IDLE (registered).
//  Two VCs completing same cycle: lower VC pulses first, other delayed one cycle (1-entry hold per VC).
//  rst asserted mid-packet: TX and RX abort immediately; no partial flits after rst.
// CONFIGURATION
//  MESH_NODE_ADAPTER_STATS_EN defined: 32-bit saturating counters tx_pkts_o, rx_pkts_o and
//   stall_cycles_o (SEND && !on_off_i[v]), cleared on rst.
//  Undefined: those ports and counters absent.
// STRUCTURE
//  noc_params package: flit_t, flit_label_t (HEAD/BODY/TAIL/HEADTAIL), VC_NUM, DEST_ADDR_SIZE_X/Y.
//  It also takes adapter_state_t {IDLE,SEL,SEND}.
//  Sub-module: ni_req_fifo (synchronous FIFO, REQ_DEPTH x {dest,len}, full/empty flags).
// TESTING
//  1 req len=1 dest(1,2), all allocatable/on -> one HEADTAIL flit, vc 0, 2 cycles after accept.
//  len=4, on_off_i[0] low 3 cycles after HEAD -> HEAD,BODY,BODY,TAIL; 3-cycle gap; no dup.
//  allocatable_i=4'b0100 -> packet on VC 2; next packet with all free -> VC 3 (RR).
//  REQ_DEPTH+1 reqs with on_off_i=0 -> req_ready_o low after REQ_DEPTH; all sent in order.
//  RX HEAD,BODY,TAIL on VC1 -> allocatable_o[1] low 2 cycles; rx_pkt_valid_o pulse, len=3.
//  RX BODY on idle VC3 -> rx_err_o[3]=1 sticky; rst mid-TX-packet -> flit_valid_o=0 next cycle.

Source files
------------

// File: rtl/noc_params.sv
// Shared mesh NoC types and sizes for the node adapter and its request queue.
//   flit_t          : one flit on the local port (label, VC, head routing fields, payload)
//   flit_label_t    : HEAD / BODY / TAIL / HEADTAIL
//   req_t           : one queued packet request (destination and length)
//   adapter_state_t : TX state encoding (IDLE / SEL / SEND)
package noc_params;

    localparam int unsigned VC_NUM           = 4;
    localparam int unsigned VC_SIZE          = $clog2(VC_NUM);
    localparam int unsigned DEST_ADDR_SIZE_X = 4;
    localparam int unsigned DEST_ADDR_SIZE_Y = 4;
    localparam int unsigned SEQ_W            = 8;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned REQ_LEN_W        = 8;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] dest_x;
        logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
        logic [DEST_ADDR_SIZE_X-1:0] src_x;
        logic [DEST_ADDR_SIZE_Y-1:0] src_y;
        logic [DATA_W-1:0]           data;
    } flit_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] dest_x;
        logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
        logic [REQ_LEN_W-1:0]        len;
    } req_t;

    typedef logic [1:0] adapter_state_t;
    localparam adapter_state_t IDLE = 2'd0;
    localparam adapter_state_t SEL  = 2'd1;
    localparam adapter_state_t SEND = 2'd2;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
        sat_inc32 = (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

endpackage

// File: rtl/ni_req_fifo.sv
// Packet request queue: synchronous FIFO of req_t with first-word fall-through read.
//   clk, rst        : clock, synchronous active-high reset
//   push_i / din_i  : write request (ignored when full)
//   pop_i / dout_o  : drop head entry (ignored when empty); dout_o is the current head
//   full_o, empty_o : occupancy flags
// DEPTH must be a power of two.
module ni_req_fifo
    import noc_params::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  req_t din_i,
    input  logic pop_i,
    output req_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;
    req_t             mem_q [DEPTH];

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    // Pointer and occupancy update.
    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wr_d    = wr_q + PTR_W'(push_ok);
        rd_d    = rd_q + PTR_W'(pop_ok);
        cnt_d   = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mesh_node_adapter.sv
// Mesh node network interface on a router local port.
//   TX: packet requests are queued, split into HEAD/BODY/TAIL (or HEADTAIL) flits,
//       sent on a round-robin-chosen allocatable VC under per-VC on/off flow control.
//   RX: flits are sunk per VC, packets reassembled, protocol errors flagged sticky.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o       : request handshake; req_dest_x_i/req_dest_y_i/req_len_i payload
//   flit_o/flit_valid_o           : flit toward the router (valid only while on_off_i[vc] is high)
//   on_off_i/allocatable_i        : router local-input per-VC credit and free status
//   flit_i/flit_valid_i           : flit from the router
//   on_off_o/allocatable_o        : per-VC space and idle status of this sink
//   rx_pkt_valid_o/rx_pkt_len_o   : one-cycle packet-complete pulse and its length
//   rx_err_o                      : sticky per-VC protocol error
// Optional MESH_NODE_ADAPTER_STATS_EN adds saturating tx_pkts_o, rx_pkts_o, stall_cycles_o.
module mesh_node_adapter
    import noc_params::*;
#(
    parameter  int unsigned REQ_DEPTH     = 4,
    parameter  int unsigned MAX_PKT_FLITS = 8,
    parameter  int unsigned X_CURRENT     = 0,
    parameter  int unsigned Y_CURRENT     = 0,
    localparam int unsigned LEN_W         = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y_i,
    input  logic [LEN_W-1:0]            req_len_i,
    output flit_t                       flit_o,
    output logic                        flit_valid_o,
    input  logic [VC_NUM-1:0]           on_off_i,
    input  logic [VC_NUM-1:0]           allocatable_i,
    input  flit_t                       flit_i,
    input  logic                        flit_valid_i,
    output logic [VC_NUM-1:0]           on_off_o,
    output logic [VC_NUM-1:0]           allocatable_o,
    output logic                        rx_pkt_valid_o,
    output logic [LEN_W-1:0]            rx_pkt_len_o,
    output logic [VC_NUM-1:0]           rx_err_o
`ifdef MESH_NODE_ADAPTER_STATS_EN
    ,
    output logic [31:0]                 tx_pkts_o,
    output logic [31:0]                 rx_pkts_o,
    output logic [31:0]                 stall_cycles_o
`endif
);

    localparam int unsigned CNT_W = LEN_W + 1;

    // ---------------- request queue ----------------
    logic alive_q;
    logic fifo_full, fifo_empty, fifo_pop, req_push;
    req_t req_in, head;

    always_ff @(posedge clk) begin
        if (rst) alive_q <= 1'b0;
        else     alive_q <= 1'b1;
    end

    assign req_ready_o = alive_q && !fifo_full;
    assign req_in      = '{dest_x: req_dest_x_i, dest_y: req_dest_y_i, len: REQ_LEN_W'(req_len_i)};
    // Zero or over-long requests are silently dropped.
    assign req_push    = req_valid_i && req_ready_o && (req_len_i != '0)
                         && (req_len_i <= LEN_W'(MAX_PKT_FLITS));

    ni_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (req_push),
        .din_i  (req_in),
        .pop_i  (fifo_pop),
        .dout_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // ---------------- TX FSM ----------------
    adapter_state_t     state_q, state_d;
    logic [VC_SIZE-1:0] vc_q, vc_d, rr_q, rr_d, pick, idx;
    logic [7:0]         k_q, k_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               pick_ok;

    always_comb begin
        state_d  = state_q;
        vc_d     = vc_q;
        rr_d     = rr_q;
        k_d      = k_q;
        seq_d    = seq_q;
        fifo_pop = 1'b0;
        pick     = '0;
        pick_ok  = 1'b0;
        idx      = '0;
        // First allocatable VC at or after the RR pointer (VC_NUM is a power of two).
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            idx = rr_q + VC_SIZE'(i);
            if (!pick_ok && allocatable_i[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
        case (state_q)
            IDLE: if (!fifo_empty) state_d = SEL;
            SEL: begin
                if (pick_ok) begin
                    vc_d    = pick;
                    rr_d    = pick + VC_SIZE'(1);
                    k_d     = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (on_off_i[vc_q]) begin
                    if (k_q == head.len - 8'd1) begin
                        fifo_pop = 1'b1;
                        seq_d    = seq_q + SEQ_W'(1);
                        state_d  = IDLE;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vc_q    <= '0;
            rr_q    <= '0;
            k_q     <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            rr_q    <= rr_d;
            k_q     <= k_d;
            seq_q   <= seq_d;
        end
    end

    // Flit is offered only while the selected VC has space; gated by rst so an abort is immediate.
    always_comb begin
        flit_o       = '0;
        flit_valid_o = (state_q == SEND) && on_off_i[vc_q] && !rst;
        if (flit_valid_o) begin
            flit_o.vc_id = vc_q;
            flit_o.data  = {seq_q, k_q};
            if (head.len == 8'd1)                 flit_o.flit_label = HEADTAIL;
            else if (k_q == '0)                   flit_o.flit_label = HEAD;
            else if (k_q == head.len - 8'd1)      flit_o.flit_label = TAIL;
            else                                  flit_o.flit_label = BODY;
            if (k_q == '0) begin
                flit_o.dest_x = head.dest_x;
                flit_o.dest_y = head.dest_y;
                flit_o.src_x  = DEST_ADDR_SIZE_X'(X_CURRENT);
                flit_o.src_y  = DEST_ADDR_SIZE_Y'(Y_CURRENT);
            end
        end
    end

    // ---------------- RX reassembly ----------------
    logic [VC_NUM-1:0]             open_q, open_d, err_q, err_d, pend_q, pend_d, alloc_q, cand;
    logic [VC_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [VC_NUM-1:0][LEN_W-1:0]  pend_len_q, pend_len_d;
    logic [VC_SIZE-1:0]            new_v, sel;
    logic [CNT_W-1:0]              cnt_inc;
    logic [LEN_W-1:0]              new_len, rx_len_q, rx_len_d;
    logic                          new_done, any, rx_valid_q, rx_valid_d;
    logic                          unused_flit_bits;

    assign unused_flit_bits = ^{flit_i.dest_x, flit_i.dest_y, flit_i.src_x, flit_i.src_y, flit_i.data};

    // Per-VC packet protocol tracking; any violation closes the VC and drops the flit.
    always_comb begin
        open_d   = open_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        new_done = 1'b0;
        new_len  = '0;
        new_v    = flit_i.vc_id;
        cnt_inc  = cnt_q[new_v] + CNT_W'(1);
        if (flit_valid_i) begin
            case (flit_i.flit_label)
                HEAD: begin
                    if (open_q[new_v]) begin
                        err_d[new_v]  = 1'b1;
                        open_d[new_v] = 1'b0;
                    end else begin
                        open_d[new_v] = 1'b1;
                        cnt_d[new_v]  = CNT_W'(1);
                    end
                end
                HEADTAIL: begin
                    if (open_q[new_v]) begin
                        err_d[new_v]  = 1'b1;
                        open_d[new_v] = 1'b0;
                    end else begin
                        new_done = 1'b1;
                        new_len  = LEN_W'(1);
                    end
                end
                BODY: begin
                    if (!open_q[new_v] || (cnt_inc > CNT_W'(MAX_PKT_FLITS))) begin
                        err_d[new_v]  = 1'b1;
                        open_d[new_v] = 1'b0;
                    end else begin
                        cnt_d[new_v] = cnt_inc;
                    end
                end
                TAIL: begin
                    open_d[new_v] = 1'b0;
                    if (!open_q[new_v] || (cnt_inc > CNT_W'(MAX_PKT_FLITS))) begin
                        err_d[new_v] = 1'b1;
                    end else begin
                        new_done = 1'b1;
                        new_len  = LEN_W'(cnt_inc);
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion report: lowest-numbered candidate goes out, the other waits in its VC hold slot.
    always_comb begin
        cand = pend_q;
        if (new_done) cand[new_v] = 1'b1;
        any = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            if (!any && cand[i]) begin
                any = 1'b1;
                sel = VC_SIZE'(i);
            end
        end
        pend_d     = pend_q;
        pend_len_d = pend_len_q;
        rx_valid_d = any;
        rx_len_d   = '0;
        if (any) begin
            if (pend_q[sel]) begin
                rx_len_d    = pend_len_q[sel];
                pend_d[sel] = 1'b0;
            end else begin
                rx_len_d = new_len;
            end
        end
        if (new_done && (pend_q[new_v] || (sel != new_v))) begin
            pend_d[new_v]     = 1'b1;
            pend_len_d[new_v] = new_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q     <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            pend_q     <= '0;
            pend_len_q <= '0;
            rx_valid_q <= 1'b0;
            rx_len_q   <= '0;
            alloc_q    <= '0;
        end else begin
            open_q     <= open_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            pend_len_q <= pend_len_d;
            rx_valid_q <= rx_valid_d;
            rx_len_q   <= rx_len_d;
            alloc_q    <= ~open_q;
        end
    end

    assign on_off_o       = {VC_NUM{alive_q}};
    assign allocatable_o  = alloc_q;
    assign rx_pkt_valid_o = rx_valid_q;
    assign rx_pkt_len_o   = rx_len_q;
    assign rx_err_o       = err_q;

`ifdef MESH_NODE_ADAPTER_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0] tx_pkts_q, tx_pkts_d, rx_pkts_q, rx_pkts_d, stall_q, stall_d;

    always_comb begin
        tx_pkts_d = sat_inc32(tx_pkts_q, fifo_pop);
        rx_pkts_d = sat_inc32(rx_pkts_q, rx_valid_q);
        stall_d   = sat_inc32(stall_q, (state_q == SEND) && !on_off_i[vc_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pkts_q <= '0;
            rx_pkts_q <= '0;
            stall_q   <= '0;
        end else begin
            tx_pkts_q <= tx_pkts_d;
            rx_pkts_q <= rx_pkts_d;
            stall_q   <= stall_d;
        end
    end

    assign tx_pkts_o      = tx_pkts_q;
    assign rx_pkts_o      = rx_pkts_q;
    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mesh_node_adapter.sv
// Directed bench for mesh_node_adapter: TX framing/latency/RR/flow control, queue full,
// RX reassembly and error handling, reset abort.
module tb_mesh_node_adapter;
    import noc_params::*;

    localparam int unsigned LEN_W = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] req_dest_x_i;
    logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y_i;
    logic [LEN_W-1:0]            req_len_i;
    flit_t                       flit_o;
    logic                        flit_valid_o;
    logic [VC_NUM-1:0]           on_off_i;
    logic [VC_NUM-1:0]           allocatable_i;
    flit_t                       flit_i;
    logic                        flit_valid_i;
    logic [VC_NUM-1:0]           on_off_o;
    logic [VC_NUM-1:0]           allocatable_o;
    logic                        rx_pkt_valid_o;
    logic [LEN_W-1:0]            rx_pkt_len_o;
    logic [VC_NUM-1:0]           rx_err_o;
`ifdef MESH_NODE_ADAPTER_STATS_EN
    logic [31:0] tx_pkts_o, rx_pkts_o, stall_cycles_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    mesh_node_adapter #(
        .REQ_DEPTH(4), .MAX_PKT_FLITS(8), .X_CURRENT(0), .Y_CURRENT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dest_x_i(req_dest_x_i), .req_dest_y_i(req_dest_y_i), .req_len_i(req_len_i),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o),
        .on_off_i(on_off_i), .allocatable_i(allocatable_i),
        .flit_i(flit_i), .flit_valid_i(flit_valid_i),
        .on_off_o(on_off_o), .allocatable_o(allocatable_o),
        .rx_pkt_valid_o(rx_pkt_valid_o), .rx_pkt_len_o(rx_pkt_len_o), .rx_err_o(rx_err_o)
`ifdef MESH_NODE_ADAPTER_STATS_EN
        , .tx_pkts_o(tx_pkts_o), .rx_pkts_o(rx_pkts_o), .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_flit(input string tag, input flit_label_t lab, input int unsigned vc,
                               input logic [15:0] data, input int unsigned dx, input int unsigned dy);
        chk({tag, "_valid"}, 64'(flit_valid_o), 64'(1));
        chk({tag, "_label"}, 64'(flit_o.flit_label), 64'(lab));
        chk({tag, "_vc"},    64'(flit_o.vc_id), 64'(vc));
        chk({tag, "_data"},  64'(flit_o.data), 64'(data));
        chk({tag, "_dx"},    64'(flit_o.dest_x), 64'(dx));
        chk({tag, "_dy"},    64'(flit_o.dest_y), 64'(dy));
        chk({tag, "_src"},   64'({flit_o.src_x, flit_o.src_y}), 64'(0));
    endtask

    task automatic set_req(input int unsigned dx, input int unsigned dy, input int unsigned len);
        req_valid_i  = 1'b1;
        req_dest_x_i = DEST_ADDR_SIZE_X'(dx);
        req_dest_y_i = DEST_ADDR_SIZE_Y'(dy);
        req_len_i    = LEN_W'(len);
    endtask

    task automatic set_rx(input flit_label_t lab, input int unsigned vc);
        flit_i            = '0;
        flit_i.flit_label = lab;
        flit_i.vc_id      = VC_SIZE'(vc);
        flit_valid_i      = 1'b1;
    endtask

    initial begin
        int  got;
        int  p;
        int  k;
        logic acc;
        rst = 1'b1; req_valid_i = 1'b0; req_dest_x_i = '0; req_dest_y_i = '0; req_len_i = '0;
        on_off_i = 4'b1111; allocatable_i = 4'b1111; flit_i = '0; flit_valid_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_flit_valid", 64'(flit_valid_o), 64'(0));
        chk("rst_flit", 64'(flit_o), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_on_off", 64'(on_off_o), 64'(0));
        chk("rst_alloc", 64'(allocatable_o), 64'(0));
        chk("rst_rx_valid", 64'(rx_pkt_valid_o), 64'(0));
        chk("rst_rx_err", 64'(rx_err_o), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_on_off", 64'(on_off_o), 64'hF);
        chk("post_rst_alloc", 64'(allocatable_o), 64'hF);
        chk("post_rst_ready", 64'(req_ready_o), 64'(1));

        // T1: single-flit packet, flit two cycles after accept on VC0
        set_req(1, 2, 1);
        tick();
        req_valid_i = 1'b0;
        chk("t1_c0", 64'(flit_valid_o), 64'(0));
        tick();
        chk("t1_c1", 64'(flit_valid_o), 64'(0));
        tick();
        expect_flit("t1_ht", HEADTAIL, 0, 16'h0000, 1, 2);
        tick();
        chk("t1_done", 64'(flit_valid_o), 64'(0));

        // T2: 4-flit packet on VC0 with a 3-cycle on/off stall after HEAD
        allocatable_i = 4'b0001;
        set_req(3, 1, 4);
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        expect_flit("t2_head", HEAD, 0, 16'h0100, 3, 1);
        tick();
        on_off_i = 4'b1110; #1;
        chk("t2_stall0", 64'(flit_valid_o), 64'(0));
        tick();
        chk("t2_stall1", 64'(flit_valid_o), 64'(0));
        tick();
        chk("t2_stall2", 64'(flit_valid_o), 64'(0));
        on_off_i = 4'b1111; #1;
        expect_flit("t2_body1", BODY, 0, 16'h0101, 0, 0);
        tick();
        expect_flit("t2_body2", BODY, 0, 16'h0102, 0, 0);
        tick();
        expect_flit("t2_tail", TAIL, 0, 16'h0103, 0, 0);
        tick();
        chk("t2_done", 64'(flit_valid_o), 64'(0));

        // T3: only VC2 allocatable, then round-robin continues at VC3
        allocatable_i = 4'b0100;
        set_req(2, 2, 2);
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        expect_flit("t3_head", HEAD, 2, 16'h0200, 2, 2);
        tick();
        expect_flit("t3_tail", TAIL, 2, 16'h0201, 0, 0);
        tick();
        chk("t3_done", 64'(flit_valid_o), 64'(0));
        allocatable_i = 4'b1111;
        set_req(0, 3, 1);
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        expect_flit("t3_rr", HEADTAIL, 3, 16'h0300, 0, 3);
        tick();
        chk("t3_rr_done", 64'(flit_valid_o), 64'(0));

        // T3b: zero and over-long lengths are dropped
        set_req(5, 5, 0);
        tick();
        set_req(5, 5, 9);
        tick();
        req_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t3b_drop", 64'(flit_valid_o), 64'(0));
            tick();
        end
        chk("t3b_ready", 64'(req_ready_o), 64'(1));

        // T4: fill the queue with flow control off, then drain in order
        on_off_i = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1, 2);
            chk("t4_ready_fill", 64'(req_ready_o), 64'(1));
            tick();
        end
        set_req(4, 1, 2);
        chk("t4_full", 64'(req_ready_o), 64'(0));
        tick();
        chk("t4_full_hold", 64'(req_ready_o), 64'(0));
        on_off_i = 4'b1111; #1;
        got = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            if (flit_valid_o) begin
                p = got / 2;
                k = got % 2;
                expect_flit("t4_flit", (k == 0) ? HEAD : TAIL, p % 4,
                            {8'(4 + p), 8'(k)}, (k == 0) ? p : 0, (k == 0) ? 1 : 0);
                got++;
            end
            acc = req_valid_i && req_ready_o;
            tick();
            if (acc) req_valid_i = 1'b0;
        end
        chk("t4_count", 64'(got), 64'(10));
        chk("t4_req_taken", 64'(req_valid_i), 64'(0));
        tick();
        chk("t4_idle", 64'(flit_valid_o), 64'(0));

        // T5: RX HEAD/BODY/TAIL on VC1, then HEADTAIL on VC2
        set_rx(HEAD, 1);
        tick();
        chk("t5_alloc_h", 64'(allocatable_o), 64'hF);
        chk("t5_nopulse", 64'(rx_pkt_valid_o), 64'(0));
        set_rx(BODY, 1);
        tick();
        chk("t5_alloc_b", 64'(allocatable_o), 64'hD);
        set_rx(TAIL, 1);
        tick();
        chk("t5_alloc_t", 64'(allocatable_o), 64'hD);
        chk("t5_pulse", 64'(rx_pkt_valid_o), 64'(1));
        chk("t5_len", 64'(rx_pkt_len_o), 64'(3));
        flit_valid_i = 1'b0;
        tick();
        chk("t5_alloc_back", 64'(allocatable_o), 64'hF);
        chk("t5_pulse_end", 64'(rx_pkt_valid_o), 64'(0));
        set_rx(HEADTAIL, 2);
        tick();
        chk("t5_ht_pulse", 64'(rx_pkt_valid_o), 64'(1));
        chk("t5_ht_len", 64'(rx_pkt_len_o), 64'(1));
        flit_valid_i = 1'b0;
        tick();
        chk("t5_ht_end", 64'(rx_pkt_valid_o), 64'(0));
        chk("t5_no_err", 64'(rx_err_o), 64'(0));

        // T6: protocol errors (BODY on idle VC3, HEAD on open VC0, overlength on VC1)
        set_rx(BODY, 3);
        tick();
        flit_valid_i = 1'b0;
        chk("t6_err3", 64'(rx_err_o), 64'h8);
        chk("t6_err3_nopulse", 64'(rx_pkt_valid_o), 64'(0));
        tick(); tick();
        chk("t6_err3_sticky", 64'(rx_err_o), 64'h8);
        set_rx(HEAD, 0);
        tick();
        set_rx(HEAD, 0);
        tick();
        flit_valid_i = 1'b0;
        chk("t6_err0", 64'(rx_err_o), 64'h9);
        set_rx(HEAD, 1);
        tick();
        set_rx(BODY, 1);
        for (int i = 0; i < 7; i++) tick();
        chk("t6_len8_ok", 64'(rx_err_o), 64'h9);
        tick();
        flit_valid_i = 1'b0;
        chk("t6_err1_over", 64'(rx_err_o), 64'hB);
        tick();
        chk("t6_err_no_pulse", 64'(rx_pkt_valid_o), 64'(0));

        // T7: reset in the middle of a TX packet
        set_req(1, 1, 4);
        tick();
        req_valid_i = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (flit_valid_o) got = 1;
            else tick();
        end
        chk("t7_started", 64'(got), 64'(1));
        expect_flit("t7_head", HEAD, 1, 16'h0900, 1, 1);
        tick();
        rst = 1'b1; #1;
        chk("t7_rst_now", 64'(flit_valid_o), 64'(0));
        tick();
        chk("t7_rst_valid", 64'(flit_valid_o), 64'(0));
        chk("t7_rst_err", 64'(rx_err_o), 64'(0));
        chk("t7_rst_alloc", 64'(allocatable_o), 64'(0));
        rst = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t7_no_partial", 64'(flit_valid_o), 64'(0));
            tick();
        end
        chk("t7_ready", 64'(req_ready_o), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
